pipeline_stall_ctrl: RTL and testbench

PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

---
 rtl/pipeline_ctrl_pkg.sv | 12 +
 rtl/pipeline_stall_ctrl_sat_counter.sv | 19 +
 rtl/pipeline_stall_ctrl.sv | 124 ++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall controller: FSM state encoding and width.
package pipeline_ctrl_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter used for the optional stall/flush performance counters.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush controller for a 5-stage pipeline: memory-wait FSM with timeout,
// hazard stalls and branch flushes. Optional counters under PIPELINE_STALL_CTRL_PERF_EN.
module pipeline_stall_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 63,
    parameter int unsigned CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hazard_detected,
    input  logic               branch_taken,
    input  logic               mem_req,
    input  logic               mem_ready,
    output logic               pc_freeze,
    output logic               if_id_freeze,
    output logic               if_id_flush,
    output logic               id_ex_bubble,
    output logic               pipe_freeze,
    output logic               mem_timeout,
    output logic [STATE_W-1:0] state
`ifdef PIPELINE_STALL_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0]   hazard_stall_cnt,
    output logic [CNT_W-1:0]   mem_wait_cnt,
    output logic [CNT_W-1:0]   flush_cnt
`endif
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(MEM_TIMEOUT);

    if (MEM_TIMEOUT < 1 || CNT_W < 1) begin : g_param_check
        $error("pipeline_stall_ctrl: MEM_TIMEOUT and CNT_W must be >= 1");
    end

    state_t            cur_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;
    logic              mf;
    logic              hazard_stall;
    logic              branch_flush;

    assign wait_nxt = wait_cnt + WAIT_W'(1);

    // The timeout compares the post-increment count, so ERROR is entered at
    // the end of the MEM_TIMEOUT-th MEM_WAIT cycle that saw no mem_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state   <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            case (cur_state)
                RUN: begin
                    if (mem_req && !mem_ready) begin
                        cur_state <= MEM_WAIT;
                        wait_cnt  <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        cur_state <= RUN;
                    end else begin
                        wait_cnt <= wait_nxt;
                        if (wait_nxt == TIMEOUT_VAL) begin
                            cur_state   <= ERROR;
                            mem_timeout <= 1'b1;
                        end
                    end
                end
                ERROR: begin
                    cur_state <= ERROR;
                end
                default: begin
                    cur_state <= RUN;
                    wait_cnt  <= '0;
                end
            endcase
        end
    end

    always_comb begin
        mf           = (mem_req && !mem_ready) || (cur_state == ERROR);
        hazard_stall = !mf && hazard_detected;
        branch_flush = !mf && !hazard_detected && branch_taken;
    end

    assign pc_freeze    = mf || hazard_stall;
    assign if_id_freeze = mf || hazard_stall;
    assign pipe_freeze  = mf;
    assign id_ex_bubble = hazard_stall;
    assign if_id_flush  = branch_flush;
    assign state        = cur_state;

`ifdef PIPELINE_STALL_CTRL_PERF_EN
    logic mem_wait_inc;

    assign mem_wait_inc = mf && (cur_state != ERROR);

    sat_counter #(.W(CNT_W)) u_hazard_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (hazard_stall),
        .count (hazard_stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_mem_wait_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (mem_wait_inc),
        .count (mem_wait_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (branch_flush),
        .count (flush_cnt)
    );
`else
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: directed scenarios then random traffic
// against a cycle-level behavioural model; counters checked when PIPELINE_STALL_CTRL_PERF_EN is set.
module tb_pipeline_stall_ctrl;

    localparam int unsigned T    = 4;
    localparam int unsigned CW   = 2;
    localparam int          CMAX = 3;

    typedef struct packed {
        logic [7:0] o;
        logic [5:0] c;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          hazard_detected = 1'b0;
    logic          branch_taken = 1'b0;
    logic          mem_req = 1'b0;
    logic          mem_ready = 1'b0;
    logic          pc_freeze, if_id_freeze, if_id_flush, id_ex_bubble, pipe_freeze, mem_timeout;
    logic [1:0]    state;
`ifdef PIPELINE_STALL_CTRL_PERF_EN
    logic [CW-1:0] hazard_stall_cnt, mem_wait_cnt, flush_cnt;
`endif

    pipeline_stall_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .hazard_detected (hazard_detected),
        .branch_taken    (branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .pc_freeze       (pc_freeze),
        .if_id_freeze    (if_id_freeze),
        .if_id_flush     (if_id_flush),
        .id_ex_bubble    (id_ex_bubble),
        .pipe_freeze     (pipe_freeze),
        .mem_timeout     (mem_timeout),
        .state           (state)
`ifdef PIPELINE_STALL_CTRL_PERF_EN
        ,
        .hazard_stall_cnt(hazard_stall_cnt),
        .mem_wait_cnt    (mem_wait_cnt),
        .flush_cnt       (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: error latched, waiting flag, count of wait cycles so far.
    bit   m_err  = 1'b0;
    bit   m_wait = 1'b0;
    int   m_w    = 0;
    int   m_hz   = 0;
    int   m_mw   = 0;
    int   m_fl   = 0;
    exp_t sb[$];
    int   tests  = 0;
    int   fails  = 0;
    int   cyc    = 0;

    function automatic int sat(input int v);
        return (v < CMAX) ? v + 1 : v;
    endfunction

    task automatic step(input bit r, input bit h, input bit b, input bit q, input bit y);
        bit   mf;
        int   st;
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; hazard_detected = h; branch_taken = b; mem_req = q; mem_ready = y;
        mf  = (q && !y) || m_err;
        st  = m_err ? 2 : (m_wait ? 1 : 0);
        e.o = {mf || h, mf || h, !mf && !h && b, !mf && h, mf, m_err, 2'(st)};
        e.c = {2'(m_hz), 2'(m_mw), 2'(m_fl)};
        sb.push_back(e);
        if (r) begin
            m_err = 0; m_wait = 0; m_w = 0; m_hz = 0; m_mw = 0; m_fl = 0;
        end else begin
            if (!mf && h) m_hz = sat(m_hz);
            if (mf && !m_err) m_mw = sat(m_mw);
            if (!mf && !h && b) m_fl = sat(m_fl);
            if (m_err) begin
                m_err = 1;
            end else if (m_wait) begin
                if (y) begin
                    m_wait = 0;
                end else begin
                    m_w = m_w + 1;
                    if (m_w == T) begin
                        m_wait = 0;
                        m_err  = 1;
                    end
                end
            end else if (q && !y) begin
                m_wait = 1;
                m_w    = 0;
            end
        end
    endtask

    // Monitor: outputs are presented every cycle, so one expectation is popped per cycle.
    initial begin
        exp_t       e;
        logic [7:0] act;
        forever begin
            @(negedge clk);
            cyc++;
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {pc_freeze, if_id_freeze, if_id_flush, id_ex_bubble, pipe_freeze, mem_timeout, state};
                tests++;
                if (act !== e.o) begin
                    fails++;
                    $display("FAIL outputs cycle %0d: got {pcf,ifz,fl,bub,pz,to,st}=%b want %b", cyc, act, e.o);
                end
`ifdef PIPELINE_STALL_CTRL_PERF_EN
                tests++;
                if ({hazard_stall_cnt, mem_wait_cnt, flush_cnt} !== e.c) begin
                    fails++;
                    $display("FAIL perf_cnt cycle %0d: got {hz,mw,fl}=%b want %b", cyc,
                             {hazard_stall_cnt, mem_wait_cnt, flush_cnt}, e.c);
                end
`endif
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        // reset then idle: everything low
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        // two hazard cycles
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        // memory wait: three cycles not ready, then ready
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0);
        // single-cycle access in RUN
        step(0, 0, 0, 1, 1);
        // hazard suppresses branch, then branch flushes
        step(0, 1, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        // branch held during a memory freeze is acted on once released
        step(0, 0, 1, 1, 0);
        step(0, 0, 1, 1, 0);
        step(0, 0, 1, 1, 1);
        // timeout into ERROR, ready afterwards does not release, reset clears
        for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 0);
        step(0, 1, 1, 1, 1);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        // reset during the second MEM_WAIT cycle, then a full-length wait from scratch
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        // five hazard cycles saturate a 2-bit counter
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        // random traffic
        for (int i = 0; i < 1500; i++) begin
            bit r;
            r = m_err ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) == 0);
            step(r, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) < 3, $urandom_range(0, 1) == 1);
        end
        repeat (3) @(posedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expectations want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
